// File: rtl/bit_serial_alu_seq_if.sv
//------------------------------------------------------------------------------
// Module      : bit_serial_alu_seq_if
// Description : Request/response handshake and 1-bit ALU slice bus for the
//               bit-serial sequencer. The optional zero flag is present only
//               when SERIAL_ALU_ZERO_FLAG_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bit_serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zero;
`endif

    logic             alu_A;
    logic             alu_B;
    logic             alu_Cin;
    logic             alu_Op0;
    logic             alu_Op1;
    logic             alu_Result;
    logic             alu_Cout;

    // Requester side
    modport master (
        output start, a, b, op, cin,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        input  zero,
`endif
        input  busy, done, result, carry
    );

    // Sequencer side: serves requests and drives the slice
    modport slave (
        input  start, a, b, op, cin,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        output zero,
`endif
        output busy, done, result, carry,
        output alu_A, alu_B, alu_Cin, alu_Op0, alu_Op1,
        input  alu_Result, alu_Cout
    );

    // The 1-bit ALU slice itself
    modport slice (
        input  alu_A, alu_B, alu_Cin, alu_Op0, alu_Op1,
        output alu_Result, alu_Cout
    );
endinterface

`default_nettype wire

// File: rtl/bit_serial_alu_seq.sv
//------------------------------------------------------------------------------
// Module      : bit_serial_alu_seq
// Description : LSB-first bit-serial AND/OR/XOR/ADD sequencer around an
//               external 1-bit ALU slice. Optional macro:
//               SERIAL_ALU_ZERO_FLAG_EN adds a registered zero flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bit_serial_alu_seq_if.slave bus
);
    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [1:0]         c_OP_ADD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [1:0]         r_op;
    logic               r_carry_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               w_accept;
    logic               w_last;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic               r_zero_acc;
    logic               r_zero;
`endif

    always_comb begin
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_last = (r_cnt == c_CNT_LAST);
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_accept     = bus.start;
                w_state_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Slice inputs are forced low outside RUN; the opcode is always visible
    always_comb begin
        bus.busy    = (r_state == S_RUN);
        bus.done    = (r_state == S_DONE);
        bus.alu_A   = 1'b0;
        bus.alu_B   = 1'b0;
        bus.alu_Cin = 1'b0;
        bus.alu_Op0 = r_op[0];
        bus.alu_Op1 = r_op[1];
        if (r_state == S_RUN) begin
            bus.alu_A   = r_a_sh[0];
            bus.alu_B   = r_b_sh[0];
            bus.alu_Cin = r_carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_op       <= '0;
            r_carry_q  <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            r_zero_acc <= 1'b0;
            r_zero     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a_sh     <= bus.a;
                r_b_sh     <= bus.b;
                r_op       <= bus.op;
                r_carry_q  <= bus.cin;
                r_res_sh   <= '0;
                r_cnt      <= '0;
                r_result   <= '0;
                r_carry    <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                r_zero_acc <= 1'b0;
                r_zero     <= 1'b0;
`endif
            end else if (r_state == S_RUN) begin
                r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_res_sh  <= {bus.alu_Result, r_res_sh[WIDTH-1:1]};
                r_carry_q <= bus.alu_Cout;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                r_zero_acc <= r_zero_acc | bus.alu_Result;
`endif
                if (!w_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    // Final bit goes straight into the published result
                    r_result <= {bus.alu_Result, r_res_sh[WIDTH-1:1]};
                    r_carry  <= (r_op == c_OP_ADD) ? bus.alu_Cout : 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    r_zero   <= ~(r_zero_acc | bus.alu_Result);
`endif
                end
            end
        end
    end

    assign bus.result = r_result;
    assign bus.carry  = r_carry;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    assign bus.zero   = r_zero;
`endif
endmodule

`default_nettype wire

// File: tb/tb_bit_serial_alu_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_bit_serial_alu_seq
// Description : Directed self-checking bench for bit_serial_alu_seq with a
//               behavioural 1-bit ALU slice on the alu_* bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bit_serial_alu_seq;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bit_serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice
    always_comb begin
        bus.alu_Result = 1'b0;
        bus.alu_Cout   = 1'b0;
        case ({bus.alu_Op1, bus.alu_Op0})
            2'b00: bus.alu_Result = bus.alu_A & bus.alu_B;
            2'b01: bus.alu_Result = bus.alu_A | bus.alu_B;
            2'b10: bus.alu_Result = bus.alu_A ^ bus.alu_B;
            default: begin
                bus.alu_Result = bus.alu_A ^ bus.alu_B ^ bus.alu_Cin;
                bus.alu_Cout   = (bus.alu_A & bus.alu_B) | (bus.alu_Cin & (bus.alu_A ^ bus.alu_B));
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.op  = op;
        bus.cin = cin;
    endtask

    // Steps until done is seen; n is the number of edges waited
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, n);
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] exp_res, input logic exp_c);
        n_checks++;
        if (bus.result !== exp_res || bus.carry !== exp_c) begin
            n_errors++;
            $display("FAIL %s: result=%h carry=%b, required result=%h carry=%b",
                     name, bus.result, bus.carry, exp_res, exp_c);
        end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        n_checks++;
        if (bus.zero !== (exp_res == 8'h00)) begin
            n_errors++;
            $display("FAIL %s zero: got %b, required %b", name, bus.zero, (exp_res == 8'h00));
        end
`endif
    endtask

    // Accept one operation, wait for done, report latency
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic cin, output int lat);
        set_op(a, b, op, cin);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(name, lat);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_op(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00 || bus.carry !== 1'b0) begin
            n_errors++;
            $display("FAIL reset outputs: busy=%b done=%b result=%h carry=%b, required 0 0 00 0",
                     bus.busy, bus.done, bus.result, bus.carry);
        end
        n_checks++;
        if ({bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Op0, bus.alu_Op1} !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset alu_bus: got %b, required 00000",
                     {bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Op0, bus.alu_Op1});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_overflow();
        int lat;
        set_op(8'hFF, 8'h01, 2'b11, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL add_busy_after_accept: busy=%b, required 1", bus.busy);
        end
        wait_done("add_ff_01", lat);
        n_checks++;
        if (lat != 8) begin
            n_errors++;
            $display("FAIL add_latency: got %0d cycles, required 8", lat);
        end
        check_result("add_ff_01", 8'h00, 1'b1);
        step();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_single_pulse: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_add_and();
        int lat;
        run_op("add_35_4a_cin", 8'h35, 8'h4A, 2'b11, 1'b1, lat);
        check_result("add_35_4a_cin", 8'h80, 1'b0);
        step();
        run_op("and_f0_3c", 8'hF0, 8'h3C, 2'b00, 1'b0, lat);
        check_result("and_f0_3c", 8'h30, 1'b0);
        step();
    endtask

    task automatic test_logic_ops();
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic [1:0] ov [2];
        logic [7:0] ev [2];
        av[0] = 8'hAA; bv[0] = 8'hFF; ov[0] = 2'b10; ev[0] = 8'h55;
        av[1] = 8'h0F; bv[1] = 8'h30; ov[1] = 2'b01; ev[1] = 8'h3F;
        for (int k = 0; k < 2; k++) begin
            int bad_op;
            int n;
            bad_op = 0;
            n      = 0;
            set_op(av[k], bv[k], ov[k], 1'b0);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            while (bus.done !== 1'b1 && n < 30) begin
                if ({bus.alu_Op1, bus.alu_Op0} !== ov[k]) bad_op++;
                step();
                n++;
            end
            n_checks++;
            if (bad_op != 0 || n != 8) begin
                n_errors++;
                $display("FAIL logic_op%0d_opcode: %0d bad opcode cycles, latency %0d, required 0 and 8",
                         k, bad_op, n);
            end
            check_result(k == 0 ? "xor_aa_ff" : "or_0f_30", ev[k], 1'b0);
            step();
        end
    endtask

    task automatic test_start_ignored();
        int n;
        int busy_gaps;
        n         = 0;
        busy_gaps = 0;
        set_op(8'hAA, 8'hFF, 2'b10, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 30) begin
            if (bus.busy !== 1'b1) busy_gaps++;
            if (n == 3 || n == 5) begin
                set_op(8'h12, 8'h34, 2'b11, 1'b1);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
            n++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (busy_gaps != 0 || n != 8) begin
            n_errors++;
            $display("FAIL start_in_run: busy gaps=%0d latency=%0d, required 0 and 8", busy_gaps, n);
        end
        check_result("start_in_run", 8'h55, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        set_op(8'h35, 8'h4A, 2'b11, 1'b1);
        bus.start = 1'b1;
        step();
        set_op(8'h0F, 8'h30, 2'b01, 1'b0);
        wait_done("b2b_first", n1);
        n_checks++;
        if (n1 != 8) begin
            n_errors++;
            $display("FAIL b2b_first_latency: got %0d, required 8", n1);
        end
        check_result("b2b_first", 8'h80, 1'b0);
        step();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
            n_errors++;
            $display("FAIL b2b_accept_in_done: busy=%b done=%b result=%h, required 1 0 00",
                     bus.busy, bus.done, bus.result);
        end
        bus.start = 1'b0;
        wait_done("b2b_second", n2);
        n_checks++;
        if (n2 != 8) begin
            n_errors++;
            $display("FAIL b2b_period: got %0d, required 9", n2 + 1);
        end
        check_result("b2b_second", 8'h3F, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int spurious;
        spurious = 0;
        run_op("pre_reset_and", 8'hF0, 8'h3C, 2'b00, 1'b0, lat);
        step();
        set_op(8'hFF, 8'h01, 2'b11, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00 || bus.carry !== 1'b0 ||
            bus.alu_Op0 !== 1'b0 || bus.alu_Op1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h carry=%b op=%b%b, required 0 0 00 0 00",
                     bus.busy, bus.done, bus.result, bus.carry, bus.alu_Op1, bus.alu_Op0);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
            step();
        end
        n_checks++;
        if (spurious != 0) begin
            n_errors++;
            $display("FAIL reset_no_done: %0d cycles with activity, required 0", spurious);
        end
        run_op("post_reset_add", 8'h35, 8'h4A, 2'b11, 1'b1, lat);
        check_result("post_reset_add", 8'h80, 1'b0);
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_op(8'h00, 8'h00, 2'b00, 1'b0);
        test_reset();
        test_add_overflow();
        test_add_and();
        test_logic_ops();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bit_serial_alu_seq.md
# bit_serial_alu_seq

Bit-serial sequencer that wraps the team's 1-bit ALU slice to perform WIDTH-bit AND/OR/XOR/ADD operations, LSB first, one bit per clock. It sits directly upstream and downstream of the slice:
- Upstream: drives the slice's A/B/Cin/Op inputs from operand shift registers.
- Downstream: captures its Result/Cout back into a result shift register and a carry flop.

The slice is instantiated outside this block and wired through the alu_* ports.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE or DONE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- op  input  2  00 AND, 01 OR, 10 XOR, 11 ADD; sampled on accepted start
- cin  input  1  carry-in for bit 0, sampled on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse: result/carry valid
- result  output  WIDTH  assembled result; held until next accepted start
- carry  output  1  final slice Cout (0 for non-ADD ops)
- alu_A, alu_B, alu_Cin, alu_Op0, alu_Op1  output  1 each  to slice
- alu_Result, alu_Cout  input  1 each  from slice

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a, b, op, cin; clear result register and bit counter; go to RUN.
  - start=0 → stay in IDLE.
- RUN, combinational slice drive:
  - alu_A = a_sh[0], alu_B = b_sh[0], alu_Cin = carry_q.
  - {alu_Op1, alu_Op0} = op_q.
- RUN, each edge:
  - a_sh and b_sh shift right.
  - result_sh shifts right with alu_Result entering at MSB.
  - carry_q ← alu_Cout.
  - cnt ← cnt+1.
  - When cnt = WIDTH−1 → DONE.
- carry_q is loaded with cin on accept, so bit 0 uses cin and bit i uses Cout of bit i−1.
- DONE: done=1 for exactly one cycle.
  - start=1 → accept new operation, go to RUN (back-to-back).
  - Otherwise → IDLE.
- start in RUN: ignored, no effect on in-flight operation or latched operands.
- Outside RUN: alu_A = alu_B = alu_Cin = 0; alu_Op* = op_q.
- result and carry change only at the RUN→DONE edge, and are cleared on an accepted start or reset.
- Counter width: clog2(WIDTH). No wrap beyond WIDTH−1.

## Timing
- Reset (rst_n=0 at an edge, any state including mid-RUN):
  - State → IDLE.
  - busy=0, done=0, result=0, carry=0, all alu_* outputs=0, op_q=0, cnt=0.
  - In-flight operation discarded; no done pulse.
- Accepting edge E0 (start=1 in IDLE/DONE): busy=1 from the cycle after E0.
- Bit i is presented to the slice during the cycle after edge E_i and captured at edge E_(i+1).
- At edge E_WIDTH: result/carry updated, busy→0, done→1.
- done is high for the cycle after E_WIDTH, so latency is WIDTH cycles from the accepting edge.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- The slice path is combinational. alu_Result/alu_Cout must settle within one clk period of the alu_* outputs.

## Configuration
- SERIAL_ALU_ZERO_FLAG_EN
  - Defined: adds output `zero` (1 bit).
    - Tracks zero_q, an OR-accumulator over captured result bits, reset at accept.
    - Registered with result: zero=1 iff result==0.
    - Valid from the done cycle; held until next accepted start; 0 on reset.
  - Undefined: port and logic absent; all other behaviour identical.

## Test plan
- WIDTH=8, op=11, a=0xFF, b=0x01, cin=0 → done exactly 8 cycles after accept; result=0x00, carry=1 (zero=1 if enabled).
- op=11, a=0x35, b=0x4A, cin=1 → result=0x80, carry=0. Then op=00, a=0xF0, b=0x3C → result=0x30, carry=0.
- op=10, a=0xAA, b=0xFF → result=0x55. op=01, a=0x0F, b=0x30 → result=0x3F. For both:
  - alu_Op1/alu_Op0 constant through RUN.
  - carry=0.
- start pulsed with different operands at cycles 3 and 5 of RUN → ignored; original result delivered; busy unbroken.
- start held high from accept through DONE → second op accepted in DONE cycle; done pulses every 9 cycles; second result correct.
- rst_n low at cycle 4 of an ADD → next cycle state IDLE, busy=0, result=0, carry=0; no done pulse; subsequent op correct.
